// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the L1 data cache controller.
//   - Address split constants (tag / index / offset / word select)
//   - Controller FSM state encoding
//   - Word extract / merge helpers for a 256-bit line of eight 32-bit words
package dcache_ctrl_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BLOCK_W    = 256;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TAG_W      = 22;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned WSEL_LSB   = 2;
    localparam int unsigned WSEL_MSB   = 4;
    localparam int unsigned WSEL_W     = WSEL_MSB - WSEL_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MISS       = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_READMISS   = 3'd3,
        ST_READMISSOK = 3'd4
    } state_e;

    function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WSEL_W-1:0]  sel);
        return blk[sel*WORD_W +: WORD_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] blk,
                                                      input logic [WSEL_W-1:0]  sel,
                                                      input logic [WORD_W-1:0]  word);
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[sel*WORD_W +: WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache controller.
//   p1_*  : MEM-stage request (addr, store data, MemRead/MemWrite), load data, stall
//   mem_* : block request to Data_Memory (addr, data, enable, write), fill data, ack
// Signal suffixes are relative to the controller.
// Modports: slave  = the cache controller
//           master = the environment (pipeline + Data_Memory)
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;

    logic [BUS_ADDR_W-1:0] p1_addr_i;
    logic [WORD_W-1:0]     p1_data_i;
    logic                  p1_MemRead_i;
    logic                  p1_MemWrite_i;
    logic [WORD_W-1:0]     p1_data_o;
    logic                  p1_stall_o;

    logic [BUS_ADDR_W-1:0] mem_addr_o;
    logic [BLOCK_W-1:0]    mem_data_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [BLOCK_W-1:0]    mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Direct-mapped line store: LINES x {valid, dirty, tag, data}.
//   idx             : line select for both read and write
//   rd_*            : asynchronous read of the selected line
//   we / wr_*       : synchronous write; a write always marks the line valid
//   rst             : asynchronous clear of valid and dirty only
module dcache_sram #(
    parameter int unsigned LINES      = 32,
    parameter int unsigned TAG_BITS   = 22,
    parameter int unsigned BLOCK_BITS = 256,
    parameter int unsigned IDX_W      = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  we,
    input  logic                  wr_dirty,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache controller: direct-mapped, write-back, write-allocate.
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus          : slave side of dcache_ctrl_if (CPU request/response + Data_Memory bus)
// Hits complete with no stall; a miss stalls the pipeline, optionally writes
// back the dirty victim, fills the line, and then lets the request re-evaluate.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned LINES      = 32,
    parameter int unsigned BLOCK_BITS = 256,
    parameter int unsigned ADDR_W     = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    dcache_ctrl_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(LINES);
    localparam int unsigned TAG_BITS = ADDR_W - IDX_W - OFFSET_W;

    state_e                state;
    logic [IDX_W-1:0]      req_idx, miss_idx, line_idx;
    logic [TAG_BITS-1:0]   req_tag, miss_tag, line_tag, wr_tag;
    logic [WSEL_W-1:0]     wsel;
    logic                  req, is_write, hit, fill_ack;
    logic                  line_valid, line_dirty;
    logic [BLOCK_BITS-1:0] line_data;
    logic                  sram_we, sram_wr_dirty;
    logic [BLOCK_BITS-1:0] sram_wr_data;
    logic                  mem_enable, mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [BLOCK_BITS-1:0] mem_data;
    logic                  unused_addr_bits;

    assign req_idx          = bus.p1_addr_i[OFFSET_W +: IDX_W];
    assign req_tag          = bus.p1_addr_i[ADDR_W-1 -: TAG_BITS];
    assign wsel             = bus.p1_addr_i[WSEL_MSB:WSEL_LSB];
    assign unused_addr_bits = ^bus.p1_addr_i[WSEL_LSB-1:0];

    // Both request bits high is treated as a store.
    assign req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign is_write = bus.p1_MemWrite_i;

    // While a miss is in flight the array is addressed by the latched miss
    // index, so the fill lands in the right line even if the request drops.
    assign line_idx = (state == ST_IDLE) ? req_idx : miss_idx;
    assign wr_tag   = (state == ST_IDLE) ? req_tag : miss_tag;
    assign hit      = line_valid && (line_tag == req_tag);
    assign fill_ack = (state == ST_READMISS) && mem_enable && bus.mem_ack_i;

    dcache_sram #(
        .LINES      (LINES),
        .TAG_BITS   (TAG_BITS),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_sram (
        .clk      (clk_i),
        .rst      (rst_i),
        .idx      (line_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (sram_we),
        .wr_dirty (sram_wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (sram_wr_data)
    );

    // Array write: store hit merges one word and dirties the line; a fill
    // installs the memory block clean.
    always_comb begin
        sram_we       = 1'b0;
        sram_wr_dirty = 1'b0;
        sram_wr_data  = bus.mem_data_i;
        if (state == ST_IDLE && req && is_write && hit) begin
            sram_we       = 1'b1;
            sram_wr_dirty = 1'b1;
            sram_wr_data  = merge_word(line_data, wsel, bus.p1_data_i);
        end else if (fill_ack) begin
            sram_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            miss_idx   <= '0;
            miss_tag   <= '0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && !hit) begin
                        state    <= ST_MISS;
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                    end
                end
                ST_MISS: begin
                    mem_enable <= 1'b1;
                    if (line_valid && line_dirty) begin
                        state     <= ST_WRITEBACK;
                        mem_write <= 1'b1;
                        mem_addr  <= {line_tag, miss_idx, {OFFSET_W{1'b0}}};
                        mem_data  <= line_data;
                    end else begin
                        state     <= ST_READMISS;
                        mem_write <= 1'b0;
                        mem_addr  <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state      <= ST_READMISS;
                        mem_enable <= 1'b0;
                        mem_write  <= 1'b0;
                    end
                end
                ST_READMISS: begin
                    // After a writeback, enable idles one cycle so every
                    // memory transaction is separated by an enable-low cycle.
                    if (!mem_enable) begin
                        mem_enable <= 1'b1;
                        mem_write  <= 1'b0;
                        mem_addr   <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                    end else if (bus.mem_ack_i) begin
                        state      <= ST_READMISSOK;
                        mem_enable <= 1'b0;
                    end
                end
                ST_READMISSOK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_enable <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

    // Stall is gated by reset: with valid cleared the request would look like
    // a miss, but the pipeline must see stall low while reset is held.
    assign bus.p1_stall_o   = !rst_i && req && ((state != ST_IDLE) || !hit);
    assign bus.p1_data_o    = hit ? word_of(line_data, wsel) : '0;
    assign bus.mem_enable_o = mem_enable;
    assign bus.mem_write_o  = mem_write;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_data_o   = mem_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores checked against a line-level reference cache and memory.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.LINES(32), .BLOCK_BITS(256), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Initial memory contents: every word distinct per block and word position.
    function automatic logic [255:0] init_blk(input logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++)
            b[w*32 +: 32] = {a[31:5], 5'b0} ^ (32'h0101_0101 * w) ^ 32'h5A00_0000;
        return b;
    endfunction

    // ---------------- memory environment ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic [255:0] env_mem [logic [31:0]];
    txn_t         txq [$];
    int unsigned  lat = 10;
    int unsigned  spur_req = 0;

    initial begin : mem_env
        bit          busy = 0;
        bit          ack_prev;
        int unsigned cnt = 0;
        int unsigned spur_done = 0;
        txn_t        cur;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ack_prev      = bus.mem_ack_i;
            bus.mem_ack_i = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (spur_done != spur_req) begin
                spur_done      = spur_req;
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = {8{$urandom}};
            end else if (busy) begin
                if (cnt > 1) cnt--;
                else begin
                    busy          = 0;
                    bus.mem_ack_i = 1'b1;
                    if (cur.wr) env_mem[cur.addr] = cur.data;
                    else bus.mem_data_i = env_mem.exists(cur.addr) ? env_mem[cur.addr] : init_blk(cur.addr);
                end
            end else if (bus.mem_enable_o && !ack_prev) begin
                cur = '{bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o};
                txq.push_back(cur);
                busy = 1;
                cnt  = lat;
            end
        end
    end

    // ---------------- reference model ----------------
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] ref_mem [logic [31:0]];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endfunction

    task automatic access(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d);
        logic [4:0]  ix = a[9:5];
        logic [21:0] t  = a[31:10];
        int unsigned w  = a[4:2];
        logic [31:0] ba = {a[31:5], 5'b0};
        bit          exp_miss;
        int unsigned n  = 0;
        txn_t        exq [$];
        @(negedge clk);
        bus.p1_addr_i     = a;
        bus.p1_data_i     = d;
        bus.p1_MemRead_i  = !wr || both;
        bus.p1_MemWrite_i = wr;
        txq.delete();
        #1;
        exp_miss = !(m_valid[ix] && m_tag[ix] == t);
        check("stall_first", 256'(bus.p1_stall_o), 256'(exp_miss));
        if (!exp_miss) check("hit_no_mem", 256'(bus.mem_enable_o), 256'(0));
        if (exp_miss) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                exq.push_back('{1'b1, {m_tag[ix], ix, 5'b0}, m_data[ix]});
                ref_mem[{m_tag[ix], ix, 5'b0}] = m_data[ix];
            end
            exq.push_back('{1'b0, ba, '0});
            m_data[ix]  = ref_mem.exists(ba) ? ref_mem[ba] : init_blk(ba);
            m_valid[ix] = 1;
            m_dirty[ix] = 0;
            m_tag[ix]   = t;
            while (bus.p1_stall_o && n < 400) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("stall_release", 256'(bus.p1_stall_o), 256'(0));
            check("txn_count", 256'(txq.size()), 256'(exq.size()));
            for (int i = 0; i < exq.size() && i < txq.size(); i++) begin
                check("txn_write", 256'(txq[i].wr), 256'(exq[i].wr));
                check("txn_addr", 256'(txq[i].addr), 256'(exq[i].addr));
                if (exq[i].wr) check("wb_data", txq[i].data, exq[i].data);
            end
        end
        if (!wr) check("load_data", 256'(bus.p1_data_o), 256'(m_data[ix][w*32 +: 32]));
        @(posedge clk);
        if (wr) begin
            m_data[ix][w*32 +: 32] = d;
            m_dirty[ix] = 1;
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned n;
        rst               = 1'b1;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 256'(bus.p1_stall_o), 256'(0));
        check("rst_enable", 256'(bus.mem_enable_o), 256'(0));
        check("rst_write", 256'(bus.mem_write_o), 256'(0));
        check("rst_maddr", 256'(bus.mem_addr_o), 256'(0));
        check("rst_mdata", bus.mem_data_o, 256'(0));
        check("rst_pdata", 256'(bus.p1_data_o), 256'(0));
        rst = 1'b0;

        // Directed scenarios
        lat = 10;
        access(0, 0, 32'h0000_0404, 32'h0);
        check("cold_word1", 256'(bus.p1_data_o), 256'(32'h0000_0400 ^ 32'h0101_0101 ^ 32'h5A00_0000));
        access(0, 0, 32'h0000_0404, 32'h0);
        access(1, 0, 32'h0000_0408, 32'hDEAD_BEEF);
        access(0, 0, 32'h0000_0808, 32'h0);
        check("evict_word2", 256'(env_mem[32'h0000_0400][95:64]), 256'(32'hDEAD_BEEF));
        access(1, 0, 32'h0000_1010, 32'h1234_5678);
        access(0, 0, 32'h0000_1010, 32'h0);
        check("alloc_merge", 256'(bus.p1_data_o), 256'(32'h1234_5678));

        // Reset while a fill is outstanding
        go_idle();
        bus.p1_addr_i    = 32'h0000_2020;
        bus.p1_MemRead_i = 1'b1;
        txq.delete();
        n = 0;
        #1;
        while (!(bus.mem_enable_o && !bus.mem_write_o) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rm_enable_seen", 256'(bus.mem_enable_o), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rm_rst_enable", 256'(bus.mem_enable_o), 256'(0));
        check("rm_rst_stall", 256'(bus.p1_stall_o), 256'(0));
        model_reset();
        bus.p1_MemRead_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(0, 0, 32'h0000_2020, 32'h0);

        // Spurious ack while idle
        go_idle();
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_enable", 256'(bus.mem_enable_o), 256'(0));
        check("spur_stall", 256'(bus.p1_stall_o), 256'(0));
        access(0, 0, 32'h0000_2024, 32'h0);

        // Random traffic over a few indices and conflicting tags
        for (int unsigned i = 0; i < 250; i++) begin
            logic [31:0] a;
            bit          wr, both;
            a    = {22'($urandom_range(1, 4)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            wr   = ($urandom_range(0, 1) == 1);
            both = wr && ($urandom_range(0, 15) == 0);
            lat  = $urandom_range(1, 6);
            access(wr, both, a, $urandom);
        end
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
